// File: rtl/dmem_pkg.sv
// ============================================================================
// dmem_pkg : shared types and constants for the data-memory bus adapter
// Revision : 1.0
// ============================================================================
`default_nettype none

package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LD_REQ  = 2'd1,
        ST_LD_WAIT = 2'd2,
        ST_LD_DONE = 2'd3
    } ld_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } sb_entry_t;

    localparam logic [3:0]  BE_FULL                = 4'b1111;
    localparam logic [31:0] WORD_MASK              = 32'hFFFF_FFFC;
    localparam int          DEFAULT_TIMEOUT_CYCLES = 256;

endpackage

`default_nettype wire

// File: rtl/dmem_store_buffer.sv
// ============================================================================
// dmem_store_buffer : one-entry posted-store holding register
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_store_buffer
    import dmem_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  sb_entry_t push_entry,
    input  logic      pop,
    output logic      valid,
    output sb_entry_t entry
);

    // Push wins over pop so a drain and a new store can share one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            entry <= '0;
        end else if (push) begin
            valid <= 1'b1;
            entry <= push_entry;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_bus_adapter.sv
// ============================================================================
// dmem_bus_adapter : load/store unit to valid/ready data-memory bus adapter
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_bus_adapter
    import dmem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        access_en,
    input  logic        cs,
    input  logic        wr,
    input  logic [3:0]  mask,
    input  logic [31:0] addr,
    input  logic [31:0] data_wr,
    output logic [31:0] data_rd,
    output logic        stall,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_we,
    output logic [3:0]  mem_req_be,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_rdata,
    output logic        bus_err
);

    localparam int              CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    ld_state_t        state;
    logic [31:0]      ld_addr_q;
    logic [31:0]      rd_q;
    logic [CNT_W-1:0] tmo_cnt;

    logic      sb_valid;
    sb_entry_t sb_entry;
    sb_entry_t sb_push_entry;
    logic      sb_push;
    logic      sb_pop;
    logic      sb_free;

    logic access;
    logic is_load;
    logic is_store;
    logic drain_req;
    logic req_hs;
    logic rsp_hit;
    logic tmo_active;
    logic tmo_hit;

    assign access    = access_en && !cs;
    assign is_load   = access && wr;
    assign is_store  = access && !wr && (mask != 4'b0000);
    assign drain_req = sb_valid && (state == ST_IDLE);
    assign req_hs    = mem_req_valid && mem_req_ready;
    assign rsp_hit   = (state == ST_LD_WAIT) && mem_rsp_valid;

    // Any handshake or response counts as progress and restarts the timeout window.
    assign tmo_active = (state == ST_LD_REQ) || (state == ST_LD_WAIT) || drain_req;
    assign tmo_hit    = tmo_active && !req_hs && !rsp_hit && (tmo_cnt == CNT_LAST);

    assign sb_pop        = drain_req && (req_hs || tmo_hit);
    assign sb_free       = !sb_valid || sb_pop;
    assign sb_push       = (state == ST_IDLE) && is_store && sb_free;
    assign sb_push_entry = '{addr: addr & WORD_MASK, be: mask, wdata: data_wr};

    dmem_store_buffer u_store_buffer (
        .clk        (clk),
        .rst        (rst),
        .push       (sb_push),
        .push_entry (sb_push_entry),
        .pop        (sb_pop),
        .valid      (sb_valid),
        .entry      (sb_entry)
    );

    always_comb begin
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_be    = 4'b0000;
        mem_req_addr  = 32'h0;
        mem_req_wdata = 32'h0;
        if (state == ST_LD_REQ) begin
            mem_req_valid = 1'b1;
            mem_req_be    = BE_FULL;
            mem_req_addr  = ld_addr_q;
        end else if (drain_req) begin
            mem_req_valid = 1'b1;
            mem_req_we    = 1'b1;
            mem_req_be    = sb_entry.be;
            mem_req_addr  = sb_entry.addr;
            mem_req_wdata = sb_entry.wdata;
        end
    end

    always_comb begin
        stall = 1'b0;
        case (state)
            ST_IDLE:    stall = is_load || (is_store && !sb_free);
            ST_LD_REQ:  stall = 1'b1;
            ST_LD_WAIT: stall = 1'b1;
            default:    stall = 1'b0;
        endcase
    end

    assign data_rd = (state == ST_LD_DONE) ? rd_q : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            ld_addr_q <= 32'h0;
            rd_q      <= 32'h0;
            bus_err   <= 1'b0;
        end else begin
            if (tmo_hit) begin
                bus_err <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (is_load && sb_free) begin
                        state     <= ST_LD_REQ;
                        ld_addr_q <= addr & WORD_MASK;
                    end
                end
                ST_LD_REQ: begin
                    if (req_hs) begin
                        state <= ST_LD_WAIT;
                    end else if (tmo_hit) begin
                        state <= ST_LD_DONE;
                        rd_q  <= 32'h0;
                    end
                end
                ST_LD_WAIT: begin
                    if (rsp_hit) begin
                        state <= ST_LD_DONE;
                        rd_q  <= mem_rsp_rdata;
                    end else if (tmo_hit) begin
                        state <= ST_LD_DONE;
                        rd_q  <= 32'h0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (!tmo_active || req_hs || rsp_hit || tmo_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_bus_adapter.sv
// ============================================================================
// tb_dmem_bus_adapter : scoreboard bench with a word-array memory reference
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_bus_adapter;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        access_en, cs, wr;
    logic [3:0]  mask;
    logic [31:0] addr, data_wr, data_rd;
    logic        stall;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [3:0]  mem_req_be;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;
    logic        bus_err;

    dmem_bus_adapter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .access_en(access_en), .cs(cs), .wr(wr),
        .mask(mask), .addr(addr), .data_wr(data_wr), .data_rd(data_rd),
        .stall(stall), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_be(mem_req_be), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_rdata(mem_rsp_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] ref_mem [0:63];
    logic [31:0] bus_mem [0:63];
    logic [31:0] exp_q [$];
    bit          manual = 1'b0;
    int          rmode = 0;
    int          dly_max = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                          input logic [31:0] d);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Every retiring load is compared with the value queued when it was issued.
    always @(negedge clk) begin
        if (!rst && access_en && !cs && wr && !stall) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL load_retire: got unexpected retire data %h, expected none", data_rd);
            end else begin
                chk("load_data", data_rd, exp_q.pop_front());
            end
        end
    end

    // Memory slave: writes always land; ready/response are driven unless in manual mode.
    initial begin
        logic        hs, hwe;
        logic [31:0] ha, hd, pdata;
        logic [3:0]  hbe;
        bit          pending;
        int          timer, zrun;
        pending = 1'b0; timer = 0; zrun = 0; pdata = 32'h0;
        forever begin
            @(negedge clk);
            hs  = !rst && mem_req_valid && mem_req_ready;
            hwe = mem_req_we; ha = mem_req_addr; hd = mem_req_wdata; hbe = mem_req_be;
            @(posedge clk); #1;
            if (!manual) mem_rsp_valid = 1'b0;
            if (hs) begin
                if (hwe) bus_mem[ha[7:2]] = merge(bus_mem[ha[7:2]], hbe, hd);
                else if (!manual) begin
                    pending = 1'b1;
                    pdata   = bus_mem[ha[7:2]];
                    timer   = $urandom_range(0, dly_max);
                end
            end
            if (!manual) begin
                if (pending) begin
                    if (timer == 0) begin
                        mem_rsp_valid = 1'b1;
                        mem_rsp_rdata = pdata;
                        pending = 1'b0;
                    end else timer--;
                end
                if (rmode == 0) mem_req_ready = 1'b1;
                else if (zrun >= 2 || $urandom_range(0, 3) != 0) begin
                    mem_req_ready = 1'b1; zrun = 0;
                end else begin
                    mem_req_ready = 1'b0; zrun++;
                end
            end
        end
    end

    task automatic do_op(input bit ld, input logic [31:0] a, input logic [3:0] m,
                         input logic [31:0] d, output int stalls);
        @(posedge clk); #1;
        access_en = 1'b1; cs = 1'b0; wr = ld; addr = a; mask = m; data_wr = d;
        if (ld) exp_q.push_back(ref_mem[a[7:2]]);
        stalls = 0;
        forever begin
            @(negedge clk);
            if (!stall) break;
            stalls++;
            if (stalls > 40) begin
                vectors++;
                miscompares++;
                $display("FAIL op_retire: got stall beyond 40 cycles, expected retire");
                break;
            end
        end
        if (!ld) ref_mem[a[7:2]] = merge(ref_mem[a[7:2]], m, d);
    endtask

    task automatic idle_cycle(input bit selected_off);
        @(posedge clk); #1;
        access_en = selected_off; cs = 1'b1; wr = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("idle_stall", {31'h0, stall}, 32'h0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_stall"}, {31'h0, stall}, 32'h0);
        chk({tag, "_data_rd"}, data_rd, 32'h0);
        chk({tag, "_req_valid"}, {31'h0, mem_req_valid}, 32'h0);
        chk({tag, "_req_we"}, {31'h0, mem_req_we}, 32'h0);
        chk({tag, "_req_be"}, {28'h0, mem_req_be}, 32'h0);
        chk({tag, "_req_addr"}, mem_req_addr, 32'h0);
        chk({tag, "_req_wdata"}, mem_req_wdata, 32'h0);
        chk({tag, "_bus_err"}, {31'h0, bus_err}, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1);
    end

    initial begin
        int          st, vcnt, k;
        bit          got;
        logic [31:0] a, d;
        logic [3:0]  m;
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = (i * 32'h0101_0101) ^ 32'hA5A5_5A5A;
            bus_mem[i] = ref_mem[i];
        end
        rst = 1'b1; access_en = 1'b0; cs = 1'b1; wr = 1'b0; mask = 4'h0;
        addr = 32'h0; data_wr = 32'h0; mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'h0;
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1 rst = 1'b0;

        // Best-case load: three stalled cycles, then the response word.
        rmode = 0; dly_max = 0;
        ref_mem[16] = 32'h1234_5678; bus_mem[16] = 32'h1234_5678;
        do_op(1'b1, 32'h40, 4'h0, 32'h0, st);
        chk("load_best_stalls", st, 3);

        do_op(1'b0, 32'h13, 4'b1000, 32'hAB00_0000, st);
        chk("store_stall", st, 0);
        @(posedge clk); #1 access_en = 1'b0;
        @(negedge clk);
        chk("store_req_valid", {31'h0, mem_req_valid}, 32'h1);
        chk("store_req_we", {31'h0, mem_req_we}, 32'h1);
        chk("store_req_addr", mem_req_addr, 32'h10);
        chk("store_req_be", {28'h0, mem_req_be}, 32'h8);
        chk("store_req_wdata", mem_req_wdata, 32'hAB00_0000);

        // Two stores against a bus held not-ready for five cycles.
        @(posedge clk); #1;
        manual = 1'b1; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        access_en = 1'b1; cs = 1'b0; wr = 1'b0; addr = 32'h20; mask = 4'hF; data_wr = 32'h1111_1111;
        @(negedge clk);
        chk("sb_first_stall", {31'h0, stall}, 32'h0);
        ref_mem[8] = merge(ref_mem[8], 4'hF, 32'h1111_1111);
        @(posedge clk); #1;
        addr = 32'h24; mask = 4'b0011; data_wr = 32'h0000_2222;
        vcnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (stall) vcnt++;
        end
        chk("sb_second_stall_cycles", vcnt, 5);
        @(posedge clk); #1 mem_req_ready = 1'b1;
        @(negedge clk);
        chk("sb_accept_on_drain", {31'h0, stall}, 32'h0);
        chk("sb_drain_addr", mem_req_addr, 32'h20);
        ref_mem[9] = merge(ref_mem[9], 4'b0011, 32'h0000_2222);
        @(posedge clk); #1 access_en = 1'b0;
        @(negedge clk);
        chk("sb_second_addr", mem_req_addr, 32'h24);
        chk("sb_second_be", {28'h0, mem_req_be}, 32'h3);
        @(posedge clk); #1 manual = 1'b0;

        // Store then load of the same word under a randomly stalling bus.
        rmode = 1; dly_max = 2;
        do_op(1'b0, 32'h30, 4'hF, 32'hC0FF_EE01, st);
        do_op(1'b1, 32'h31, 4'h0, 32'h0, st);

        for (int n = 0; n < 250; n++) begin
            k = $urandom_range(0, 7);
            a = 32'($urandom_range(0, 63));
            if (k <= 2) begin
                do_op(1'b1, a, 4'h0, 32'h0, st);
            end else if (k <= 5) begin
                m = 4'($urandom_range(0, 15));
                d = $urandom;
                do_op(1'b0, a, m, d, st);
                if (m == 4'h0) chk("nop_store_stall", st, 0);
            end else begin
                idle_cycle(k == 7);
            end
        end
        repeat (6) idle_cycle(1'b0);

        // Load that never gets ready: aborted after the timeout window.
        @(posedge clk); #1;
        manual = 1'b1; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        access_en = 1'b1; cs = 1'b0; wr = 1'b1; addr = 32'h8; mask = 4'h0;
        exp_q.push_back(32'h0);
        vcnt = 0; got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_err) begin
                got = 1'b1;
                break;
            end
            if (mem_req_valid) vcnt++;
        end
        chk("tmo_bus_err", {31'h0, got}, 32'h1);
        chk("tmo_wait_cycles", vcnt, TMO);
        chk("tmo_stall", {31'h0, stall}, 32'h0);
        chk("tmo_data_rd", data_rd, 32'h0);
        @(posedge clk); #1 access_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("tmo_sticky", {31'h0, bus_err}, 32'h1);

        // Reset while waiting for a response; the late response must be dropped.
        @(posedge clk); #1;
        mem_req_ready = 1'b1;
        access_en = 1'b1; cs = 1'b0; wr = 1'b1; addr = 32'h40;
        got = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mem_req_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk("rst_load_issued", {31'h0, got}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b1; access_en = 1'b0; mem_req_ready = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midrst");
        @(posedge clk); #1;
        rst = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("stale_rsp_data_rd", data_rd, 32'h0);
        chk("stale_rsp_req_valid", {31'h0, mem_req_valid}, 32'h0);
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0; manual = 1'b0; rmode = 0; dly_max = 0;
        @(negedge clk);
        chk("stale_rsp_after", data_rd, 32'h0);
        do_op(1'b1, 32'h40, 4'h0, 32'h0, st);
        chk("post_rst_load_stalls", st, 3);

        repeat (3) idle_cycle(1'b0);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
